// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one uart_tx among NREQ byte producers; tx_en pulses the cycle after accept, one byte per frame.
// req_ready only in IDLE with the serializer idle. Macro UART_ARB_PRIO0_EN makes requester 0 fixed top priority.
module uart_tx_arbiter #(
    parameter int NREQ         = 4,
    parameter int GAP_CYCLES   = 0,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx_en,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic [2:0]        owner,
    output logic              active,
    output logic              err_timeout,
    input  logic              err_clr
);

    localparam int            IW       = $clog2(NREQ);
    localparam int            TW       = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST  = TW'(BUSY_TIMEOUT - 1);
    localparam logic [7:0]    GAP_LAST = (GAP_CYCLES > 1) ? 8'(GAP_CYCLES - 1) : 8'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   to_cnt;
    logic [7:0]      gap_cnt;
    logic            to_set;
    logic [IW-1:0]   scan_idx;
    logic [2:0]      grant_idx;
    logic            grant_found;
    logic [NREQ-1:0] grant_oh;
    logic [7:0]      sel_byte;
    logic            accept;

    // Scan owner+1, owner+2, ... so the last winner drops to lowest priority.
    always_comb begin
        grant_idx   = 3'd0;
        grant_found = 1'b0;
        scan_idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_idx = IW'((int'(owner) + k) % NREQ);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = 3'(scan_idx);
            end
        end
`ifdef UART_ARB_PRIO0_EN
        if (req_valid[0]) begin
            grant_found = 1'b1;
            grant_idx   = 3'd0;
        end
`endif
    end

    always_comb begin
        sel_byte = 8'h00;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_idx == 3'(k)) begin
                sel_byte = req_data[8*k +: 8];
            end
        end
    end

    assign grant_oh  = {{(NREQ-1){1'b0}}, 1'b1} << grant_idx;
    assign req_ready = (resetn && state == S_IDLE && !tx_busy && grant_found) ? grant_oh : '0;
    assign accept    = |(req_valid & req_ready);
    assign tx_en     = (state == S_LAUNCH);
    assign active    = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        to_set    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt = S_WAIT_DONE;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt = S_GAP;
                    to_set    = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) state_nxt = S_GAP;
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tx_data     <= 8'h00;
            owner       <= 3'(NREQ - 1);
            err_timeout <= 1'b0;
            to_cnt      <= '0;
            gap_cnt     <= 8'd0;
        end else begin
            if (accept) begin
                tx_data <= sel_byte;
                owner   <= grant_idx;
            end
            // Both counters rest at zero outside their own state, so entry needs no explicit clear.
            if (state == S_WAIT_BUSY) to_cnt <= to_cnt + 1'b1;
            else                      to_cnt <= '0;
            if (state == S_GAP) gap_cnt <= gap_cnt + 1'b1;
            else                gap_cnt <= 8'd0;
            if (to_set)       err_timeout <= 1'b1;
            else if (err_clr) err_timeout <= 1'b0;
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer among NREQ byte producers (CPU port, debug monitor, trace unit, and so on).
- Uses round-robin arbitration and a valid/ready byte handshake per requester.
- Sequences each frame: launch pulse, wait for busy, wait for done, optional inter-frame gap.
- Sits between the requesters and the uart_tx instance; drives its uart_tx_en and uart_tx_data and observes uart_tx_busy.

Parameters:
- NREQ, 4, number of requesters (2..8).
- GAP_CYCLES, 0, idle clocks forced between the end of one frame and the next grant (0..255).
- BUSY_TIMEOUT, 16, clocks allowed after launch for tx_busy to rise before the frame is abandoned.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset, synchronous, active-low.
- req_valid  in  NREQ  requester i has a byte pending.
- req_data  in  8*NREQ  byte of requester i in bits [8i+7:8i].
- req_ready  out  NREQ  one-hot; a byte is taken when req_valid[i] and req_ready[i] are high at the same edge.
- tx_en  out  1  launch pulse to uart_tx (uart_tx_en).
- tx_data  out  8  byte to uart_tx (uart_tx_data).
- tx_busy  in  1  uart_tx_busy.
- owner  out  3  index of the last granted requester.
- active  out  1  high in any state other than IDLE.
- err_timeout  out  1  sticky; set on busy timeout.
- err_clr  in  1  clears err_timeout.

Behaviour:
- Reset (resetn low at a clk edge):
  - state=IDLE; tx_en=0; tx_data=0; owner=NREQ-1, so requester 0 wins first; err_timeout=0; counters=0.
  - req_ready=0 while resetn is low.
  - Reset mid-frame abandons the frame. The serializer is reset by the same signal.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE:
  - req_ready is combinational: grant g is the first i with req_valid[i]=1, scanning owner+1, owner+2, ... modulo NREQ.
  - req_ready[g]=1 only when state=IDLE, tx_busy=0 and some req_valid is high. Otherwise req_ready=0.
  - At the accepting edge: tx_data<=req_data[g], owner<=g, tx_en<=1, state->LAUNCH.
- LAUNCH: lasts exactly one cycle with tx_en=1. Next edge: tx_en<=0, timeout counter<=0, state->WAIT_BUSY.
- WAIT_BUSY:
  - tx_busy=1 -> WAIT_DONE.
  - Else the counter increments. When the counter reaches BUSY_TIMEOUT-1 with busy still low: err_timeout<=1, state->GAP.
- WAIT_DONE: tx_busy=0 -> GAP.
- GAP:
  - Counts GAP_CYCLES clocks, then -> IDLE.
  - With GAP_CYCLES=0 it lasts one cycle, so the minimum re-arbitration distance is 1 clock after busy falls.
- Throughput: exactly one byte accepted per frame. No requester is granted twice while another asserts valid (round-robin fairness).
- tx_data holds its value from LAUNCH until the next accept.
- A requester dropping req_valid while not ready is legal. It must not drop valid in the cycle it is ready (protocol rule; the bench checks this).
- err_timeout:
  - err_clr=1 clears it.
  - Set has priority over clear in the same cycle.
  - After a timeout, arbitration continues normally.
- tx_busy high in IDLE (e.g. external use of the serializer) blocks all grants.
- owner width is fixed at 3; the upper bits are 0 when NREQ<8.

Optional Feature:
- Macro UART_ARB_PRIO0_EN.
- Defined: requester 0 is fixed highest priority. If req_valid[0]=1 in IDLE, it is granted regardless of owner. Round-robin applies only among requesters 1..NREQ-1, and owner updates as normal.
- Undefined: pure round-robin over all requesters as above.

Test Plan:
- Reset, then req_valid=4'b0001 with byte 0x55 -> req_ready[0] high for 1 cycle; tx_en one-cycle pulse with tx_data=0x55; owner=0; model busy 10 cycles -> active falls after busy falls + GAP.
- All four valid with bytes 0xA0..0xA3, held -> grant order 0,1,2,3,0; exactly one byte per frame; tx_data sequence A0,A1,A2,A3,A0.
- Model never raises tx_busy, BUSY_TIMEOUT=16 -> err_timeout sets 16 cycles after LAUNCH; next valid still granted; err_clr pulse clears it; simultaneous set+clr leaves it 1.
- GAP_CYCLES=5, two back-to-back requesters -> exactly 5 GAP cycles plus 1 IDLE cycle between busy falling and the next tx_en.
- Pull resetn low during WAIT_DONE -> next cycle state=IDLE, tx_en=0, req_ready=0, err_timeout=0, owner=NREQ-1.
- With UART_ARB_PRIO0_EN defined: req 0 and req 2 held valid -> req 0 is granted every frame; with the macro undefined -> 0,2,0,2 alternation.
